// File: rtl/periph_console.sv
// periph_console: memory-mapped console / simulation-control peripheral.
// Channel writes feed one shared {chan, data} FIFO drained over a valid/ready
// stream; STATUS/EXIT/TIMER registers; sticky halt once exit is pending and
// all queued output has drained.
// Optional feature macro: PERIPH_CONSOLE_TIMER_EN (free-running cycle timer).
module periph_console #(
   parameter logic [31:0] BASE_ADDR = 32'hc000_0000,
   parameter int unsigned CHANNELS  = 2,
   parameter int unsigned DEPTH     = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] paddr,
   input  logic [31:0] pwrite,
   output logic [31:0] pread,
   input  logic        pread_req,
   input  logic        pwrite_req,
   input  logic [2:0]  psize,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [3:0]  out_chan,
   output logic        halt,
   output logic [31:0] exit_code
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [31:0] OFF_STATUS = 32'h40;
   localparam logic [31:0] OFF_EXIT   = 32'h44;
   localparam logic [31:0] OFF_TIMER  = 32'h48;

   logic              rst_sync_q;
   logic              rst_n;
   logic [31:0]       off;
   logic [3:0]        ch_idx;
   logic              is_chan;
   logic [31:0]       wdata;
   logic              wr_chan, wr_status, wr_exit;
   logic              full, empty, push, pop;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              exit_pending_q, exit_pending_d;
   logic              halt_q, halt_d;
   logic [31:0]       exit_code_q, exit_code_d;
   logic [31:0]       mem_data_q [DEPTH];
   logic [31:0]       mem_data_d [DEPTH];
   logic [3:0]        mem_chan_q [DEPTH];
   logic [3:0]        mem_chan_d [DEPTH];
   logic [31:0]       status;
   logic [31:0]       timer_rd;

   // Reset release is delayed one edge so the first write lands on the second edge
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) rst_sync_q <= 1'b0;
      else        rst_sync_q <= 1'b1;
   end
   assign rst_n = rst_sync_q;

   // Address decode and psize write-data masking
   always_comb begin
      off       = paddr - BASE_ADDR;
      ch_idx    = off[5:2];
      is_chan   = (off < OFF_STATUS) && (off[1:0] == 2'b00) && (32'(ch_idx) < CHANNELS);
      wr_chan   = pwrite_req && is_chan;
      wr_status = pwrite_req && (off == OFF_STATUS);
      wr_exit   = pwrite_req && (off == OFF_EXIT);
      case (psize)
         3'd1:    wdata = {24'd0, pwrite[7:0]};
         3'd2:    wdata = {16'd0, pwrite[15:0]};
         default: wdata = pwrite;
      endcase
   end

   // FIFO control, overflow, exit and halt next-state
   always_comb begin
      full           = (count_q == CNT_W'(DEPTH));
      empty          = (count_q == '0);
      pop            = !empty && out_ready;
      push           = wr_chan && (!full || pop);
      wr_ptr_d       = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d       = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      count_d        = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
      overflow_d     = wr_status ? 1'b0 : (overflow_q | (wr_chan && full && !pop));
      exit_pending_d = exit_pending_q | wr_exit;
      exit_code_d    = wr_exit ? wdata : exit_code_q;
      halt_d         = halt_q | (exit_pending_q && empty && !push);
   end

   // FIFO storage next-state
   always_comb begin
      mem_data_d = mem_data_q;
      mem_chan_d = mem_chan_q;
      if (push) begin
         mem_data_d[wr_ptr_q] = wdata;
         mem_chan_d[wr_ptr_q] = ch_idx;
      end
   end

   // FIFO storage (no reset; head is masked while empty)
   always_ff @(posedge clock) begin
      mem_data_q <= mem_data_d;
      mem_chan_q <= mem_chan_d;
   end

   // Control state registers
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         overflow_q     <= 1'b0;
         exit_pending_q <= 1'b0;
         exit_code_q    <= '0;
         halt_q         <= 1'b0;
      end else begin
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         overflow_q     <= overflow_d;
         exit_pending_q <= exit_pending_d;
         exit_code_q    <= exit_code_d;
         halt_q         <= halt_d;
      end
   end

`ifdef PERIPH_CONSOLE_TIMER_EN
   logic [31:0] timer_q, timer_d;

   // Free-running cycle counter, frozen once halted
   always_comb begin
      timer_d = halt_q ? timer_q : timer_q + 32'd1;
   end

   // Timer register
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) timer_q <= '0;
      else        timer_q <= timer_d;
   end
   assign timer_rd = timer_q;
`else
   assign timer_rd = 32'd0;
`endif

   // Status word and combinational read mux
   always_comb begin
      status = {15'd0, 9'(count_q), 4'd0, exit_pending_q, overflow_q, empty, full};
      pread  = '0;
      if (pread_req) begin
         if (off == OFF_STATUS)     pread = status;
         else if (off == OFF_TIMER) pread = timer_rd;
      end
   end

   assign out_valid = !empty;
   assign out_data  = empty ? 32'd0 : mem_data_q[rd_ptr_q];
   assign out_chan  = empty ? 4'd0  : mem_chan_q[rd_ptr_q];
   assign halt      = halt_q;
   assign exit_code = exit_code_q;

endmodule
